// File: rtl/dino_pkg.sv
// Shared geometry, obstacle sizes and game-state encoding for the obstacle
// generator and its neighbours in the render pipeline.
package dino_pkg;

    localparam int SCREEN_W  = 640;
    localparam int GROUND_Y  = 400;
    localparam int NUM_SLOTS = 2;

    localparam logic signed [10:0] OBS0_W = 11'sd16;
    localparam logic signed [10:0] OBS1_W = 11'sd24;
    localparam logic [9:0]         OBS0_H = 10'd32;
    localparam logic [9:0]         OBS1_H = 10'd48;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    function automatic logic signed [10:0] obs_width(input logic t);
        return t ? OBS1_W : OBS0_W;
    endfunction

    function automatic logic [9:0] obs_height(input logic t);
        return t ? OBS1_H : OBS0_H;
    endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR (taps 16,14,13,11) used as the obstacle
// randomness source; reloads SEED on reset.
module lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] o_lfsr
);

    logic [15:0] r_lfsr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr <= SEED;
        end else begin
            r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
        end
    end

    assign o_lfsr = r_lfsr;

endmodule

// File: rtl/obstacle_gen.sv
// Obstacle game logic (two scrolling slots, random spawning, speed ramp) and
// the 1-clk registered obstacle pixel feeding the compositor.
module obstacle_gen
    import dino_pkg::*;
#(
    parameter logic [8:0] MIN_GAP        = 9'd160,
    parameter logic [3:0] SPEED_INIT     = 4'd4,
    parameter logic [3:0] SPEED_MAX      = 4'd12,
    parameter int         SPEED_UP_TICKS = 512
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] i_hpos,
    input  logic [9:0] i_vpos,
    input  logic       i_game_tick_60hz,
    input  logic       i_game_start_pulse,
    input  logic       i_collision,
    output logic       o_color_obstacle,
    output logic       o_running,
    output logic [3:0] o_speed
);

    localparam logic signed [10:0] SPAWN_X   = 11'(SCREEN_W);
    localparam logic [9:0]         GROUND    = 10'(GROUND_Y);
    localparam logic [8:0]         TICK_LAST = 9'(SPEED_UP_TICKS - 1);

    state_t                r_state, w_state_nx;
    logic [NUM_SLOTS-1:0]  r_active, w_active_nx;
    logic [NUM_SLOTS-1:0]  r_type, w_type_nx;
    logic signed [10:0]    r_x    [NUM_SLOTS];
    logic signed [10:0]    w_x_nx [NUM_SLOTS];
    logic [3:0]            r_speed, w_speed_nx;
    logic [8:0]            r_spawn_cnt, w_spawn_cnt_nx;
    logic [8:0]            r_tick_cnt, w_tick_cnt_nx;
    logic                  r_color;
    logic                  w_do_tick, w_spawned, w_hit;
    logic signed [10:0]    w_hpos;
    logic [15:0]           w_lfsr;
    logic                  w_unused_lfsr;

    lfsr16 #(.SEED(16'hACE1)) u_lfsr (
        .clk    (clk),
        .rst    (rst),
        .o_lfsr (w_lfsr)
    );

    assign w_unused_lfsr = ^w_lfsr[15:7];
    assign w_do_tick     = (r_state == RUN) && i_game_tick_60hz && !i_game_start_pulse;
    assign w_hpos        = $signed({1'b0, i_hpos});

    always_comb begin
        w_state_nx = r_state;
        if (i_game_start_pulse) begin
            w_state_nx = RUN;
        end else if (r_state == RUN && i_collision) begin
            w_state_nx = HALT;
        end
    end

    // Retirement happens before the free-slot search, so a slot leaving this tick can be reused at once
    always_comb begin
        w_active_nx    = r_active;
        w_type_nx      = r_type;
        w_x_nx         = r_x;
        w_spawn_cnt_nx = r_spawn_cnt;
        w_tick_cnt_nx  = r_tick_cnt;
        w_speed_nx     = r_speed;
        w_spawned      = 1'b0;
        if (w_do_tick) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (r_active[i]) begin
                    w_x_nx[i]      = r_x[i] - $signed({7'd0, r_speed});
                    w_active_nx[i] = (w_x_nx[i] + obs_width(r_type[i])) > 11'sd0;
                end
            end
            if (r_spawn_cnt <= {5'd0, r_speed}) begin
                w_spawn_cnt_nx = 9'd0;
                for (int i = 0; i < NUM_SLOTS; i++) begin
                    if (!w_spawned && !w_active_nx[i]) begin
                        w_spawned      = 1'b1;
                        w_active_nx[i] = 1'b1;
                        w_x_nx[i]      = SPAWN_X;
                        w_type_nx[i]   = w_lfsr[0];
                        w_spawn_cnt_nx = MIN_GAP + {1'b0, w_lfsr[6:1], 2'b00};
                    end
                end
            end else begin
                w_spawn_cnt_nx = r_spawn_cnt - {5'd0, r_speed};
            end
            if (r_tick_cnt == TICK_LAST) begin
                w_tick_cnt_nx = 9'd0;
                if (r_speed < SPEED_MAX) begin
                    w_speed_nx = r_speed + 4'd1;
                end
            end else begin
                w_tick_cnt_nx = r_tick_cnt + 9'd1;
            end
        end
    end

    always_comb begin
        w_hit = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (r_active[i] && w_hpos >= r_x[i] && w_hpos < r_x[i] + obs_width(r_type[i])
                && i_vpos >= GROUND - obs_height(r_type[i]) && i_vpos < GROUND) begin
                w_hit = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_active    <= '0;
            r_type      <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                r_x[i] <= '0;
            end
            r_speed     <= SPEED_INIT;
            r_spawn_cnt <= MIN_GAP;
            r_tick_cnt  <= '0;
            r_color     <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_color <= w_hit && (r_state != IDLE);
            if (i_game_start_pulse) begin
                r_active    <= '0;
                r_speed     <= SPEED_INIT;
                r_spawn_cnt <= MIN_GAP;
                r_tick_cnt  <= '0;
            end else begin
                r_active    <= w_active_nx;
                r_type      <= w_type_nx;
                r_x         <= w_x_nx;
                r_speed     <= w_speed_nx;
                r_spawn_cnt <= w_spawn_cnt_nx;
                r_tick_cnt  <= w_tick_cnt_nx;
            end
        end
    end

    assign o_color_obstacle = r_color;
    assign o_running        = (r_state == RUN);
    assign o_speed          = r_speed;

endmodule
